// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM states, IF/ID register contents and the canonical NOP.
package if_stage_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [ILEN-1:0] inst;
        logic            valid;
    } ifid_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory read port: single outstanding request, response strobe.
interface if_stage_if;
    import if_stage_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            imem_rvalid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_rvalid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_rvalid
    );

endinterface

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register. Flush beats stall; an idle unstalled cycle
// injects a bubble (NOP, valid=0) while keeping the last pc/pc4.
module ifid_reg
    import if_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  stall_i,
    input  logic  flush_i,
    input  logic  load_i,
    input  ifid_t load_data_i,
    output ifid_t ifid_o
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (flush_i || (!stall_i && !load_i)) begin
            ifid_d.valid = 1'b0;
            ifid_d.inst  = NOP_INST;
        end else if (!stall_i) begin
            ifid_d = load_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q.pc    <= '0;
            ifid_q.pc4   <= '0;
            ifid_q.inst  <= NOP_INST;
            ifid_q.valid <= 1'b0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_o = ifid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one imem read at a time, parks a response
// in a one-entry buffer while decode is stalled, and kills in-flight reads on redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             next_pc_src,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             stall,
    if_stage_if.master       imem,
    output logic [XLEN-1:0]  ifid_pc,
    output logic [XLEN-1:0]  ifid_pc4,
    output logic [ILEN-1:0]  ifid_inst,
    output logic             ifid_valid
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [ILEN-1:0] buf_inst_q, buf_inst_d;

    logic  ifid_load;
    ifid_t ifid_load_data;
    ifid_t ifid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ISSUE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            buf_pc_q   <= '0;
            buf_inst_q <= NOP_INST;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        kill_d         = kill_q;
        buf_pc_d       = buf_pc_q;
        buf_inst_d     = buf_inst_q;
        ifid_load      = 1'b0;
        ifid_load_data = '{pc: pc_q, pc4: pc_q + 32'd4, inst: imem.imem_rdata, valid: 1'b1};

        case (state_q)
            ST_ISSUE: begin
                // The request is already on the bus; a redirect can only poison its reply.
                state_d = ST_WAIT;
                if (next_pc_src) kill_d = 1'b1;
            end
            ST_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (kill_q || next_pc_src) begin
                        kill_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end else if (!stall) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        state_d   = ST_ISSUE;
                    end else begin
                        buf_pc_d   = pc_q;
                        buf_inst_d = imem.imem_rdata;
                        state_d    = ST_HOLD;
                    end
                end else if (next_pc_src) begin
                    kill_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (next_pc_src) begin
                    state_d = ST_ISSUE;
                end else if (!stall) begin
                    ifid_load      = 1'b1;
                    ifid_load_data = '{pc: buf_pc_q, pc4: buf_pc_q + 32'd4,
                                       inst: buf_inst_q, valid: 1'b1};
                    pc_d           = pc_q + 32'd4;
                    state_d        = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_ISSUE;
                kill_d  = 1'b0;
            end
        endcase

        if (next_pc_src) pc_d = pc_align(branch_target);
    end

    // Reset gates the request and pins the address so nothing leaks out mid-reset.
    always_comb begin
        imem.imem_req  = (state_q == ST_ISSUE) && !rst;
        imem.imem_addr = rst ? RESET_PC : pc_q;
    end

    ifid_reg u_ifid_reg (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall),
        .flush_i     (next_pc_src),
        .load_i      (ifid_load),
        .load_data_i (ifid_load_data),
        .ifid_o      (ifid)
    );

    assign ifid_pc    = ifid.pc;
    assign ifid_pc4   = ifid.pc4;
    assign ifid_inst  = ifid.inst;
    assign ifid_valid = ifid.valid;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 next_pc_src  input  1  taken-redirect from branch unit, same cycle as branch_target.
REQ-005 branch_target  input  32  redirect address.
REQ-006 stall  input  1  hazard-unit hold of the IF/ID register.
REQ-007 imem_req  output  1  instruction-memory read request, one-cycle pulse.
REQ-008 imem_addr  output  32  read address; valid while imem_req=1.
REQ-009 imem_rdata  input  32  returned instruction; valid while imem_rvalid=1.
REQ-010 imem_rvalid  input  1  response strobe, at least 1 cycle after imem_req; one outstanding request maximum.
REQ-011 ifid_pc  output  32  PC of the instruction in IF/ID.
REQ-012 ifid_pc4  output  32  ifid_pc+4.
REQ-013 ifid_inst  output  32  instruction in IF/ID.
REQ-014 ifid_valid  output  1  IF/ID holds a real instruction.

Function
REQ-015 The FSM SHALL have states ISSUE, WAIT, HOLD.
REQ-016 ISSUE: imem_req=1, imem_addr=pc; always go to WAIT next cycle.
REQ-017 WAIT: imem_req=0; stay until imem_rvalid=1.
REQ-018 WAIT, rvalid=1, no kill, stall=0: load IF/ID {pc, pc+4, rdata, valid=1}, pc<=pc+4, go ISSUE.
REQ-019 WAIT, rvalid=1, no kill, stall=1: capture rdata and pc into a one-entry buffer, go HOLD.
REQ-020 HOLD: when stall=0, load IF/ID from buffer with valid=1, pc<=pc+4, go ISSUE.
REQ-021 stall=1 without redirect: IF/ID SHALL hold all fields unchanged.
REQ-022 stall=0 and no instruction loaded this cycle: IF/ID SHALL take valid=0, inst=32'h0000_0013 (NOP), pc/pc4 unchanged.
REQ-023 next_pc_src=1: pc<={branch_target[31:2],2'b00}; IF/ID flushed (valid=0, NOP) regardless of stall (flush beats stall).
REQ-024 Redirect in WAIT: set kill flag; the next response SHALL be discarded, kill cleared, then go ISSUE at the new pc.
REQ-025 Redirect in WAIT coincident with rvalid=1: response discarded, go ISSUE next cycle at target; kill not left set.
REQ-026 Redirect in HOLD: buffer discarded, go ISSUE; redirect in ISSUE: request still goes out and its response is killed.
REQ-027 imem_rvalid in ISSUE or HOLD SHALL be ignored.
REQ-028 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-029 Latency: with rvalid 1 cycle after req and stall=0, ifid_valid rises 2 cycles after imem_req; peak throughput one instruction per 2 cycles.

Reset
REQ-030 rst=1 SHALL force: pc=RESET_PC, state=ISSUE, kill=0, buffer empty, imem_req=0, imem_addr=RESET_PC, ifid_valid=0, ifid_inst=NOP, ifid_pc=0, ifid_pc4=0.
REQ-031 First cycle after rst falls, imem_req=1 with imem_addr=RESET_PC.
REQ-032 rst asserted mid-WAIT SHALL abandon the request; any rvalid during or after reset before the next request SHALL be ignored.

Structure
REQ-033 Shared package SHALL hold the FSM state enum, the NOP constant 32'h0000_0013 and the instruction/address width constants.
REQ-034 The IF/ID register with stall/flush SHALL be one sub-module, ifid_reg; FSM, pc and buffer stay in if_stage.

Verification
REQ-035 Reset release, rvalid 1 cycle after each req, rdata=0xA0+n -> ifid_pc 0,4,8 with ifid_valid high every second cycle.
REQ-036 stall=1 across a response at pc=8 -> state HOLD, IF/ID unchanged; stall drops -> ifid_pc=8, inst correct, next req addr=12.
REQ-037 next_pc_src=1, target=0x103 in WAIT, rvalid 2 cycles later -> response dropped, next imem_addr=0x100, IF/ID NOP/valid=0.
REQ-038 Redirect target 0x200 coincident with rvalid and stall=1 -> IF/ID flushed, response dropped, next req addr=0x200.
REQ-039 RESET_PC=32'hFFFF_FFFC -> second request addr=0x0.
REQ-040 rst pulse mid-WAIT with late rvalid -> response ignored, first request after reset addr=RESET_PC.
